// File: rtl/ascon_multi_counter.sv
// ascon_multi_counter -- NUM_CH independent down-counters with per-channel
// load, one-shot / auto-reload mode, zero flag and registered terminal-count
// pulse. A global halt freezes decrements but never blocks loads.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   halt_i            freeze all decrements
//   load_i[c]         load count_i slice c into count and reload registers
//   autoreload_i[c]   mode captured on load (1 = auto-reload, 0 = one-shot)
//   count_i           load values, channel c at [c*WIDTH +: WIDTH]
//   en_i[c]           decrement enable
//   count_o           current counts, same packing as count_i
//   zero_o[c]         combinational count == 0
//   tc_o[c]           one-cycle pulse after a 1 -> terminal decrement
//   all_zero_o        AND of zero_o
//
// Optional feature, enabled by defining ASCON_CNT_STICKY_DONE_EN:
//   done_clr_i[c]     clear sticky done
//   done_o[c]         sticky done, set by a terminal event (set beats clear)

module ascon_multi_counter_ch #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_i,
  input  logic             load_i,
  input  logic             autoreload_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
`ifdef ASCON_CNT_STICKY_DONE_EN
  input  logic             done_clr_i,
  output logic             done_o,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q;
  logic             dec, term;

  // Load masks the decrement, so a load landing on count 1 never pulses tc.
  assign dec  = en_i && !halt_i && !load_i && (count_q != '0);
  assign term = dec && (count_q == WIDTH'(1));

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      mode_d   = autoreload_i;
    end else if (term) begin
      count_d  = mode_q ? reload_q : '0;
    end else if (dec) begin
      count_d  = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= term;
    end
  end

`ifdef ASCON_CNT_STICKY_DONE_EN
  logic done_q, done_d;

  // Terminal event is checked first so it wins over a same-cycle clear.
  always_comb begin
    done_d = done_q;
    if (term)                      done_d = 1'b1;
    else if (done_clr_i || load_i) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done_o = done_q;
`endif

  assign count_o = count_q;
  assign tc_o    = tc_q;
endmodule

module ascon_multi_counter #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    halt_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH-1:0]       autoreload_i,
  input  logic [NUM_CH*WIDTH-1:0] count_i,
  input  logic [NUM_CH-1:0]       en_i,
`ifdef ASCON_CNT_STICKY_DONE_EN
  input  logic [NUM_CH-1:0]       done_clr_i,
  output logic [NUM_CH-1:0]       done_o,
`endif
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       zero_o,
  output logic [NUM_CH-1:0]       tc_o,
  output logic                    all_zero_o
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ascon_multi_counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .halt_i       (halt_i),
      .load_i       (load_i[c]),
      .autoreload_i (autoreload_i[c]),
      .load_val_i   (count_i[c*WIDTH +: WIDTH]),
      .en_i         (en_i[c]),
`ifdef ASCON_CNT_STICKY_DONE_EN
      .done_clr_i   (done_clr_i[c]),
      .done_o       (done_o[c]),
`endif
      .count_o      (count_o[c*WIDTH +: WIDTH]),
      .tc_o         (tc_o[c])
    );
    assign zero_o[c] = (count_o[c*WIDTH +: WIDTH] == '0);
  end

  assign all_zero_o = &zero_o;
endmodule

// File: tb/tb_ascon_multi_counter.sv
// Bench for ascon_multi_counter: a behavioural model pushes expected state
// into a queue each cycle; the entry is popped and compared after the edge.
// Scenario tasks add fixed-value checks on top of the model.
module tb_ascon_multi_counter;
  localparam int W = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           halt_i;
  logic [N-1:0]   load_i, autoreload_i, en_i;
  logic [N*W-1:0] count_i;
  logic [N*W-1:0] count_o;
  logic [N-1:0]   zero_o, tc_o;
  logic           all_zero_o;
  logic [N-1:0]   done_clr_i;
`ifdef ASCON_CNT_STICKY_DONE_EN
  logic [N-1:0]   done_o;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   tc;
    logic [N-1:0]   done;
  } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] m_cnt [N];
  logic [W-1:0] m_rel [N];
  logic         m_mode[N];
  logic         m_tc  [N];
  logic         m_done[N];

  ascon_multi_counter #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt_i       (halt_i),
    .load_i       (load_i),
    .autoreload_i (autoreload_i),
    .count_i      (count_i),
    .en_i         (en_i),
`ifdef ASCON_CNT_STICKY_DONE_EN
    .done_clr_i   (done_clr_i),
    .done_o       (done_o),
`endif
    .count_o      (count_o),
    .zero_o       (zero_o),
    .tc_o         (tc_o),
    .all_zero_o   (all_zero_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle: model the edge from the current inputs, queue the
  // expectation, then pop and compare once the DUT has settled.
  task automatic step();
    exp_t e, g;
    logic [N-1:0] ez;
    for (int c = 0; c < N; c++) begin
      if (!rst_n) begin
        m_cnt[c] = '0; m_rel[c] = '0; m_mode[c] = 1'b0; m_tc[c] = 1'b0; m_done[c] = 1'b0;
      end else if (load_i[c]) begin
        m_cnt[c]  = count_i[c*W +: W];
        m_rel[c]  = count_i[c*W +: W];
        m_mode[c] = autoreload_i[c];
        m_tc[c]   = 1'b0;
        m_done[c] = 1'b0;
      end else if (en_i[c] && !halt_i && m_cnt[c] != 0) begin
        if (m_cnt[c] == 1) begin
          m_tc[c]   = 1'b1;
          m_done[c] = 1'b1;
          m_cnt[c]  = m_mode[c] ? m_rel[c] : '0;
        end else begin
          m_tc[c]  = 1'b0;
          m_cnt[c] = m_cnt[c] - 1;
          if (done_clr_i[c]) m_done[c] = 1'b0;
        end
      end else begin
        m_tc[c] = 1'b0;
        if (done_clr_i[c]) m_done[c] = 1'b0;
      end
      e.cnt[c*W +: W] = m_cnt[c];
      e.tc[c]         = m_tc[c];
      e.done[c]       = m_done[c];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    for (int c = 0; c < N; c++) ez[c] = (g.cnt[c*W +: W] == 0);
    checks++;
    if (count_o !== g.cnt) begin
      errors++; $display("FAIL model count_o got %h exp %h", count_o, g.cnt);
    end
    checks++;
    if (tc_o !== g.tc) begin
      errors++; $display("FAIL model tc_o got %b exp %b", tc_o, g.tc);
    end
    checks++;
    if (zero_o !== ez) begin
      errors++; $display("FAIL model zero_o got %b exp %b", zero_o, ez);
    end
    checks++;
    if (all_zero_o !== (&ez)) begin
      errors++; $display("FAIL model all_zero_o got %b exp %b", all_zero_o, &ez);
    end
`ifdef ASCON_CNT_STICKY_DONE_EN
    checks++;
    if (done_o !== g.done) begin
      errors++; $display("FAIL model done_o got %b exp %b", done_o, g.done);
    end
`endif
  endtask

  task automatic idle_inputs();
    halt_i = 0; load_i = '0; autoreload_i = '0; en_i = '0; count_i = '0; done_clr_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    load_i = 2'b11; count_i = 8'h77;   // reset overrides load
    step(); step();
    rst_n = 1; idle_inputs();
    step();
    checks++;
    if (count_o !== '0 || zero_o !== 2'b11 || all_zero_o !== 1'b1 || tc_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got cnt=%h z=%b az=%b tc=%b exp cnt=00 z=11 az=1 tc=00",
               count_o, zero_o, all_zero_o, tc_o);
    end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] ec[5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic         et[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    idle_inputs(); load_i = 2'b01; count_i = 8'h03;
    step();
    checks++;
    if (count_o[3:0] !== 4'd3) begin
      errors++; $display("FAIL oneshot_load got %0d exp 3", count_o[3:0]);
    end
    idle_inputs(); en_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count_o[3:0] !== ec[i] || tc_o[0] !== et[i]) begin
        errors++;
        $display("FAIL oneshot[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                 i, count_o[3:0], tc_o[0], ec[i], et[i]);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [W-1:0] ec[6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    logic         et[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    idle_inputs(); load_i = 2'b10; autoreload_i = 2'b10; count_i = 8'h20;
    step();
    checks++;
    if (count_o[7:4] !== 4'd2) begin
      errors++; $display("FAIL autoreload_load got %0d exp 2", count_o[7:4]);
    end
    idle_inputs(); en_i = 2'b10;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (count_o[7:4] !== ec[i] || tc_o[1] !== et[i]) begin
        errors++;
        $display("FAIL autoreload[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                 i, count_o[7:4], tc_o[1], ec[i], et[i]);
      end
    end
    // reload value 1: tc on every enabled cycle, count parked at 1
    idle_inputs(); load_i = 2'b10; autoreload_i = 2'b10; count_i = 8'h10;
    step();
    idle_inputs(); en_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count_o[7:4] !== 4'd1 || tc_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL reload_one[%0d] got cnt=%0d tc=%b exp cnt=1 tc=1", i, count_o[7:4], tc_o[1]);
      end
    end
    idle_inputs(); step();
  endtask

  task automatic test_load_priority();
    idle_inputs(); load_i = 2'b01; count_i = 8'h02;
    step();
    idle_inputs(); en_i = 2'b01;
    step();                                      // count 1
    load_i = 2'b01; count_i = 8'h05;             // load while at 1 with en
    step();
    checks++;
    if (count_o[3:0] !== 4'd5 || tc_o[0] !== 1'b0) begin
      errors++; $display("FAIL load_over_term got cnt=%0d tc=%b exp cnt=5 tc=0", count_o[3:0], tc_o[0]);
    end
    idle_inputs(); en_i = 2'b01; halt_i = 1;
    step(); step();
    checks++;
    if (count_o[3:0] !== 4'd5) begin
      errors++; $display("FAIL halt_freeze got %0d exp 5", count_o[3:0]);
    end
    load_i = 2'b01; count_i = 8'h07;             // halt must not block a load
    step();
    checks++;
    if (count_o[3:0] !== 4'd7) begin
      errors++; $display("FAIL halt_load got %0d exp 7", count_o[3:0]);
    end
    idle_inputs(); step();
  endtask

  task automatic test_zero_reset();
    idle_inputs(); load_i = 2'b01; count_i = 8'h00;
    step();
    idle_inputs(); en_i = 2'b01;
    step();
    checks++;
    if (zero_o[0] !== 1'b1 || tc_o[0] !== 1'b0) begin
      errors++; $display("FAIL load_zero got z=%b tc=%b exp z=1 tc=0", zero_o[0], tc_o[0]);
    end
    idle_inputs(); load_i = 2'b01; count_i = 8'h04;
    step();
    idle_inputs(); en_i = 2'b01;
    step(); step();                              // count 2
    rst_n = 0; load_i = 2'b01; count_i = 8'h09;
    step();
    rst_n = 1; idle_inputs(); en_i = 2'b01;
    step();
    checks++;
    if (count_o[3:0] !== 4'd0 || tc_o[0] !== 1'b0) begin
      errors++; $display("FAIL reset_midcount got cnt=%0d tc=%b exp cnt=0 tc=0", count_o[3:0], tc_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      halt_i       = ($urandom_range(0, 7) == 0);
      load_i       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      autoreload_i = N'($urandom);
      count_i      = (N*W)'($urandom_range(0, 3) | ($urandom_range(0, 3) << W));
      en_i         = N'($urandom);
      done_clr_i   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
    end
    idle_inputs();
  endtask

`ifdef ASCON_CNT_STICKY_DONE_EN
  task automatic test_done();
    idle_inputs(); load_i = 2'b01; count_i = 8'h01;
    step();
    idle_inputs(); en_i = 2'b01;
    step();
    checks++;
    if (done_o[0] !== 1'b1) begin
      errors++; $display("FAIL done_set got %b exp 1", done_o[0]);
    end
    idle_inputs(); done_clr_i = 2'b01;
    step();
    checks++;
    if (done_o[0] !== 1'b0) begin
      errors++; $display("FAIL done_clr got %b exp 0", done_o[0]);
    end
    idle_inputs(); load_i = 2'b01; count_i = 8'h01;
    step();
    idle_inputs(); en_i = 2'b01; done_clr_i = 2'b01;
    step();
    checks++;
    if (done_o[0] !== 1'b1) begin
      errors++; $display("FAIL done_set_wins got %b exp 1", done_o[0]);
    end
    idle_inputs(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_load_priority();
    test_zero_reset();
`ifdef ASCON_CNT_STICKY_DONE_EN
    test_done();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
